// File: rtl/core_pkg.sv
// Shared types and sizing for the out-of-order core's reorder buffer.
package core_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int TAG_W       = $clog2(ROB_ENTRIES);
    localparam int XLEN        = 32;

    typedef logic [TAG_W-1:0] rob_tag_t;

    // One in-flight instruction as tracked between dispatch and retirement.
    typedef struct packed {
        logic            busy;
        logic            done;
        logic            has_rd;
        logic [4:0]      rd;
        logic [XLEN-1:0] value;
        logic            mispredict;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion,
// in-order single retirement per cycle, full flush on a mispredicting head.
module reorder_buffer
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_valid,
    input  logic            alloc_has_rd,
    input  logic [4:0]      alloc_rd,
    input  logic [XLEN-1:0] alloc_pc,
    output logic            alloc_ready,
    output rob_tag_t        alloc_tag,
    input  logic            cdb_valid,
    input  rob_tag_t        cdb_tag,
    input  logic [XLEN-1:0] cdb_value,
    input  logic            cdb_mispredict,
    input  logic [XLEN-1:0] cdb_target,
    input  rob_tag_t        src_tag,
    output logic            src_done,
    output logic [XLEN-1:0] src_value,
    output logic            commit_valid,
    output logic            commit_we,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_value,
    output logic            flush,
    output logic [XLEN-1:0] flush_pc,
    output logic            rob_empty
);

    localparam logic [TAG_W:0] ROB_FULL = (TAG_W + 1)'(ROB_ENTRIES);

    rob_entry_t     entries_q [ROB_ENTRIES];
    rob_entry_t     entries_d [ROB_ENTRIES];
    rob_tag_t       head_q;
    rob_tag_t       head_d;
    rob_tag_t       tail_q;
    rob_tag_t       tail_d;
    logic [TAG_W:0] count_q;
    logic [TAG_W:0] count_d;

    rob_entry_t     head_entry_s;
    logic           alloc_fire_s;
    logic           cdb_hit_s;

    // Status, allocation handshake and the retiring-head view.
    always_comb begin
        head_entry_s = entries_q[head_q];
        alloc_ready  = (count_q != ROB_FULL);
        alloc_tag    = tail_q;
        alloc_fire_s = alloc_valid && alloc_ready;
        rob_empty    = (count_q == {(TAG_W + 1){1'b0}});
        cdb_hit_s    = cdb_valid && entries_q[cdb_tag].busy;
        // A reset cycle never retires, even if the head happens to be done.
        commit_valid = !reset && head_entry_s.busy && head_entry_s.done;
        commit_we    = commit_valid && head_entry_s.has_rd && (head_entry_s.rd != 5'd0);
        commit_rd    = head_entry_s.rd;
        commit_value = head_entry_s.value;
        flush        = commit_valid && head_entry_s.mispredict;
        flush_pc     = head_entry_s.target;
    end

    // Operand lookup for rename, forwarding a same-cycle CDB result.
    always_comb begin
        if (cdb_hit_s && (cdb_tag == src_tag)) begin
            src_done  = 1'b1;
            src_value = cdb_value;
        end else begin
            src_done  = entries_q[src_tag].done;
            src_value = entries_q[src_tag].value;
        end
    end

    // Next-state for entries and pointers; a flush overrides all other updates.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                entries_d[i].busy = 1'b0;
            end
            head_d  = {TAG_W{1'b0}};
            tail_d  = {TAG_W{1'b0}};
            count_d = {(TAG_W + 1){1'b0}};
        end else begin
            if (cdb_hit_s) begin
                entries_d[cdb_tag].done       = 1'b1;
                entries_d[cdb_tag].value      = cdb_value;
                entries_d[cdb_tag].mispredict = cdb_mispredict;
                entries_d[cdb_tag].target     = cdb_target;
            end else begin
                entries_d[cdb_tag] = entries_q[cdb_tag];
            end
            if (alloc_fire_s) begin
                entries_d[tail_q].busy       = 1'b1;
                entries_d[tail_q].done       = 1'b0;
                entries_d[tail_q].has_rd     = alloc_has_rd;
                entries_d[tail_q].rd         = alloc_rd;
                entries_d[tail_q].value      = {XLEN{1'b0}};
                entries_d[tail_q].mispredict = 1'b0;
                entries_d[tail_q].target     = {XLEN{1'b0}};
                entries_d[tail_q].pc         = alloc_pc;
                tail_d                       = tail_q + 1'b1;
            end else begin
                tail_d = tail_q;
            end
            // Retire last so the head slot ends the cycle free.
            if (commit_valid) begin
                entries_d[head_q].busy = 1'b0;
                head_d                 = head_q + 1'b1;
            end else begin
                head_d = head_q;
            end
            count_d = count_q + (TAG_W + 1)'(alloc_fire_s) - (TAG_W + 1)'(commit_valid);
        end
    end

    // State registers with synchronous reset that discards every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                entries_q[i] <= {$bits(rob_entry_t){1'b0}};
            end
            head_q  <= {TAG_W{1'b0}};
            tail_q  <= {TAG_W{1'b0}};
            count_q <= {(TAG_W + 1){1'b0}};
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at
// allocation and compared whenever the DUT reports a commit.
module tb_reorder_buffer;
    import core_pkg::*;

    logic            clk;
    logic            reset;
    logic            alloc_valid;
    logic            alloc_has_rd;
    logic [4:0]      alloc_rd;
    logic [XLEN-1:0] alloc_pc;
    logic            alloc_ready;
    rob_tag_t        alloc_tag;
    logic            cdb_valid;
    rob_tag_t        cdb_tag;
    logic [XLEN-1:0] cdb_value;
    logic            cdb_mispredict;
    logic [XLEN-1:0] cdb_target;
    rob_tag_t        src_tag;
    logic            src_done;
    logic [XLEN-1:0] src_value;
    logic            commit_valid;
    logic            commit_we;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_value;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            rob_empty;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .src_tag(src_tag), .src_done(src_done), .src_value(src_value),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
        .commit_value(commit_value), .flush(flush), .flush_pc(flush_pc),
        .rob_empty(rob_empty)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        fl;
        logic [31:0] pc;
    } exp_t;

    exp_t       exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_commits = 0;
    logic [3:0] mtail = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request one entry; queue its eventual retirement if it must be accepted.
    task automatic do_alloc(input bit has_rd, input logic [4:0] rd, input logic [31:0] val,
                            input bit mis, input logic [31:0] tgt, input bit accept);
        exp_t e;
        alloc_valid  = 1'b1;
        alloc_has_rd = has_rd;
        alloc_rd     = rd;
        alloc_pc     = 32'h1000 + 32'(mtail) * 32'd4;
        #1;
        check("alloc_ready", alloc_ready, accept);
        if (accept) begin
            check("alloc_tag", alloc_tag, mtail);
            e.we = has_rd && (rd != 5'd0);
            e.rd = rd; e.value = val; e.fl = mis; e.pc = tgt;
            exp_q.push_back(e);
            mtail = mtail + 4'd1;
        end
        step();
        alloc_valid = 1'b0;
    endtask

    // Broadcast a result, checking the same-cycle operand bypass on its tag.
    task automatic do_cdb(input logic [3:0] tag, input logic [31:0] val,
                          input bit mis, input logic [31:0] tgt);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
        cdb_mispredict = mis; cdb_target = tgt; src_tag = tag;
        #1;
        check("bypass_done", src_done, 1'b1);
        check("bypass_value", src_value, val);
        step();
        cdb_valid = 1'b0; cdb_mispredict = 1'b0;
    endtask

    // Commit monitor: every retirement must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (commit_valid) begin
                n_commits++;
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_rd", commit_rd, e.rd);
                    check("commit_we", commit_we, e.we);
                    check("commit_value", commit_value, e.value);
                    check("commit_flush", flush, e.fl);
                    if (e.fl) begin
                        check("flush_pc", flush_pc, e.pc);
                        exp_q.delete();
                    end
                end
            end else begin
                check("flush_idle", flush, 1'b0);
            end
        end
    end

    initial begin
        logic [3:0] t_a;
        logic [3:0] t_b;
        reset = 1'b1;
        alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = 5'd0; alloc_pc = 32'd0;
        cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'd0;
        cdb_mispredict = 1'b0; cdb_target = 32'd0; src_tag = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_alloc_ready", alloc_ready, 1'b1);
        check("rst_rob_empty", rob_empty, 1'b1);
        check("rst_alloc_tag", alloc_tag, 4'd0);
        check("rst_commit_valid", commit_valid, 1'b0);
        check("rst_flush", flush, 1'b0);

        // In-order retire despite reverse completion order.
        do_alloc(1'b1, 5'd5, 32'd10, 1'b0, 32'd0, 1'b1);
        do_alloc(1'b1, 5'd6, 32'd20, 1'b0, 32'd0, 1'b1);
        do_alloc(1'b1, 5'd7, 32'd30, 1'b0, 32'd0, 1'b1);
        do_cdb(4'd2, 32'd30, 1'b0, 32'd0);
        src_tag = 4'd2;
        #1;
        check("stored_src_done", src_done, 1'b1);
        check("stored_src_value", src_value, 32'd30);
        do_cdb(4'd1, 32'd20, 1'b0, 32'd0);
        check("no_early_commit", n_commits, 0);
        check("head_not_done", commit_valid, 1'b0);
        do_cdb(4'd0, 32'd10, 1'b0, 32'd0);
        check("retire0", commit_valid, 1'b1);
        step();
        check("retire1", commit_valid, 1'b1);
        step();
        check("retire2", commit_valid, 1'b1);
        step();
        check("drained", rob_empty, 1'b1);

        // Reset mid-operation with a done head: no commit, everything dropped.
        t_a = mtail;
        do_alloc(1'b1, 5'd9, 32'd1, 1'b0, 32'd0, 1'b1);
        do_cdb(t_a, 32'd1, 1'b0, 32'd0);
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("reset_no_commit", commit_valid, 1'b0);
        step();
        reset = 1'b0;
        mtail = 4'd0;
        #1;
        check("reset_empty", rob_empty, 1'b1);
        check("reset_tag", alloc_tag, 4'd0);

        // Fill, refuse, retire one, wrap.
        for (int i = 0; i < 16; i++) begin
            do_alloc(1'b1, 5'(i + 1), 32'd100 + 32'(i), 1'b0, 32'd0, 1'b1);
        end
        check("full_not_empty", rob_empty, 1'b0);
        do_alloc(1'b1, 5'd20, 32'd0, 1'b0, 32'd0, 1'b0);
        do_cdb(4'd0, 32'd100, 1'b0, 32'd0);
        check("full_head_commit", commit_valid, 1'b1);
        do_alloc(1'b1, 5'd21, 32'd0, 1'b0, 32'd0, 1'b0);
        do_alloc(1'b1, 5'd17, 32'd200, 1'b0, 32'd0, 1'b1);
        check("refilled", alloc_ready, 1'b0);
        for (int t = 1; t < 16; t++) begin
            do_cdb(4'(t), 32'd100 + 32'(t), 1'b0, 32'd0);
        end
        do_cdb(4'd0, 32'd200, 1'b0, 32'd0);
        for (int i = 0; i < 40 && !rob_empty; i++) step();
        check("wrap_drained", rob_empty, 1'b1);
        check("wrap_scoreboard", exp_q.size(), 0);

        // x0 destination, plus allocate and commit on the same edge.
        t_a = mtail;
        do_alloc(1'b1, 5'd0, 32'd99, 1'b0, 32'd0, 1'b1);
        do_cdb(t_a, 32'd99, 1'b0, 32'd0);
        check("x0_commit_valid", commit_valid, 1'b1);
        check("x0_commit_we", commit_we, 1'b0);
        t_b = mtail;
        do_alloc(1'b1, 5'd3, 32'd7, 1'b0, 32'd0, 1'b1);
        check("swap_not_empty", rob_empty, 1'b0);
        check("swap_no_commit", commit_valid, 1'b0);
        do_cdb(t_b, 32'd7, 1'b0, 32'd0);
        step();
        check("swap_empty", rob_empty, 1'b1);

        // Mispredicted branch at head squashes three done younger entries.
        t_a = mtail;
        do_alloc(1'b0, 5'd0, 32'd0, 1'b1, 32'd128, 1'b1);
        for (int i = 0; i < 3; i++) begin
            do_alloc(1'b1, 5'(10 + i), 32'd500 + 32'(i), 1'b0, 32'd0, 1'b1);
        end
        for (int i = 1; i < 4; i++) begin
            do_cdb(t_a + 4'(i), 32'd500 + 32'(i - 1), 1'b0, 32'd0);
        end
        do_cdb(t_a, 32'd0, 1'b1, 32'd128);
        check("br_flush", flush, 1'b1);
        check("br_flush_pc", flush_pc, 32'd128);
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd13;
        step();
        alloc_valid = 1'b0;
        mtail = 4'd0;
        #1;
        check("post_flush_empty", rob_empty, 1'b1);
        check("post_flush_tag", alloc_tag, 4'd0);
        check("post_flush_pulse", flush, 1'b0);
        check("post_flush_commit", commit_valid, 1'b0);

        // JAL: link write proceeds together with the redirect.
        t_a = mtail;
        do_alloc(1'b1, 5'd24, 32'd132, 1'b1, 32'h200, 1'b1);
        src_tag = t_a;
        #1;
        check("jal_src_pending", src_done, 1'b0);
        do_cdb(t_a, 32'd132, 1'b1, 32'h200);
        check("jal_we", commit_we, 1'b1);
        check("jal_flush", flush, 1'b1);
        step();
        check("jal_empty", rob_empty, 1'b1);
        step();
        check("final_scoreboard", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
